// File: rtl/bist_engine.sv
// ============================================================================
// Module   : bist_engine
// Brief    : Logic BIST controller with LFSR pattern source, scan sequencing and MISR compaction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_engine #(
  parameter int                N_IN       = 3,
  parameter int                N_OUT      = 2,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h01,
  parameter int                MISR_W     = 8,
  parameter logic [MISR_W-1:0] MISR_TAPS  = 8'hB8,
  parameter int                SCAN_LEN   = 4,
  parameter int                N_PATTERNS = 16,
  parameter logic [MISR_W-1:0] GOLDEN     = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic [N_IN-1:0]   func_in,
  output logic [N_IN-1:0]   cut_in,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  input  logic [N_OUT-1:0]  cut_resp,
  output logic              running,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
);

  localparam int SC_W = $clog2(SCAN_LEN + 1);
  localparam int PC_W = $clog2(N_PATTERNS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    FLUSH   = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [LFSR_W-1:0] lfsr;
  logic [MISR_W-1:0] misr;
  logic [SC_W-1:0]   shift_cnt;
  logic [PC_W-1:0]   pat_cnt;
  logic              pass_fail_q;

  logic              active;
  logic              shift_last;
  logic              more_pat;
  logic              misr_upd;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [MISR_W-1:0] resp_vec;
  logic [MISR_W-1:0] misr_nxt;

  assign active     = (state != IDLE) && (state != DONE);
  assign shift_last = (shift_cnt == SC_W'(SCAN_LEN - 1));
  assign more_pat   = (pat_cnt < PC_W'(N_PATTERNS - 1));
  assign misr_upd   = (state == SHIFT) || (state == CAPTURE) || (state == FLUSH);
  assign lfsr_adv   = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  assign misr_nxt   = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ resp_vec;

  // Response word: scan_out in bit 0, CUT outputs above it, zero-extended
  always_comb begin
    resp_vec            = '0;
    resp_vec[N_OUT:0]   = {cut_resp, scan_out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    cut_in    = func_in;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    running   = active;
    bist_end  = (state == DONE);
    pass_fail = pass_fail_q;
    signature = misr;
    if (active) begin
      cut_in = lfsr[N_IN-1:0];
    end
    case (state)
      IDLE:    if (bist_start) state_d = SEED;
      SEED:    state_d = SHIFT;
      SHIFT: begin
        scan_en = 1'b1;
        scan_in = lfsr[LFSR_W-1];
        if (shift_last) state_d = CAPTURE;
      end
      CAPTURE: state_d = more_pat ? SHIFT : FLUSH;
      FLUSH: begin
        scan_en = 1'b1;
        if (shift_last) state_d = COMPARE;
      end
      COMPARE: state_d = DONE;
      DONE:    if (!bist_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort outranks every in-run transition
    if (active && bist_abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      misr        <= '0;
      shift_cnt   <= '0;
      pat_cnt     <= '0;
      pass_fail_q <= 1'b0;
    end else if (state == SEED) begin
      lfsr        <= LFSR_SEED;
      misr        <= '0;
      shift_cnt   <= '0;
      pat_cnt     <= '0;
      pass_fail_q <= 1'b0;
    end else begin
      // Lockup guard: an all-zero LFSR would never leave zero on its own
      if (lfsr == '0) begin
        lfsr <= LFSR_W'(1);
      end else if (state == SHIFT) begin
        lfsr <= lfsr_adv;
      end
      if (misr_upd) begin
        misr <= misr_nxt;
      end
      if ((state == SHIFT) || (state == FLUSH)) begin
        shift_cnt <= shift_last ? '0 : shift_cnt + SC_W'(1);
      end
      if (state == CAPTURE) begin
        pat_cnt <= pat_cnt + PC_W'(1);
      end
      if (active && bist_abort) begin
        pass_fail_q <= 1'b0;
      end else if (state == COMPARE) begin
        pass_fail_q <= (misr == GOLDEN);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/bist_engine.md
BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 Parameter N_IN, default 3: CUT primary inputs driven by the engine; 1 <= N_IN <= LFSR_W.
REQ-002 Parameter N_OUT, default 2: CUT primary outputs compacted; N_OUT+1 <= MISR_W.
REQ-003 Parameter LFSR_W, default 8: pattern-generator width.
REQ-004 Parameter LFSR_TAPS, default 8'hB8: LFSR feedback mask.
REQ-005 Parameter LFSR_SEED, default 8'h01: LFSR load value at run start.
REQ-006 Parameter MISR_W, default 8: signature width.
REQ-007 Parameter MISR_TAPS, default 8'hB8: MISR feedback mask.
REQ-008 Parameter SCAN_LEN, default 4 (>=1): scan-chain length in flops.
REQ-009 Parameter N_PATTERNS, default 16 (>=1): capture cycles per run.
REQ-010 Parameter GOLDEN, default 8'h00: expected final signature.
REQ-011 CLK in 1: single clock, all state on rising edge.
REQ-012 RST in 1: asynchronous, active-high reset.
REQ-013 bist_start, bist_abort in 1: run request; abort of an active run.
REQ-014 func_in in N_IN: functional inputs; cut_in out N_IN: muxed CUT inputs.
REQ-015 scan_en out 1; scan_in out 1; scan_out in 1: scan-chain control, serial in, serial out.
REQ-016 cut_resp in N_OUT: CUT primary outputs.
REQ-017 running, bist_end, pass_fail out 1: run active; run complete; signature matched.
REQ-018 signature out MISR_W: current MISR contents.

Function
REQ-019 FSM states IDLE, SEED, SHIFT, CAPTURE, FLUSH, COMPARE, DONE.
REQ-020 IDLE: cut_in = func_in combinationally, scan_en=0, running=0; bist_start=1 -> SEED.
REQ-021 SEED (1 cycle): LFSR <= LFSR_SEED, MISR <= 0, pattern and shift counters <= 0, pass_fail <= 0 -> SHIFT.
REQ-022 SHIFT (SCAN_LEN cycles): scan_en=1, scan_in=LFSR[LFSR_W-1], LFSR advances each cycle -> CAPTURE.
REQ-023 CAPTURE (1 cycle): scan_en=0, pattern counter +1; -> SHIFT if counter was < N_PATTERNS-1, else FLUSH.
REQ-024 FLUSH (SCAN_LEN cycles): scan_en=1, scan_in=0, LFSR holds -> COMPARE.
REQ-025 COMPARE (1 cycle): pass_fail <= (MISR == GOLDEN) -> DONE.
REQ-026 DONE: bist_end=1, pass_fail held; bist_start=0 -> IDLE; bist_end clears on leaving DONE.
REQ-027 SEED..COMPARE: running=1, cut_in = LFSR[N_IN-1:0].
REQ-028 LFSR: Fibonacci, left shift, new LSB = XOR(LFSR & LFSR_TAPS); all-zero state forced to 1 next cycle (lockup guard).
REQ-029 MISR updates in SHIFT, CAPTURE, FLUSH: next = {MISR[MISR_W-2:0], XOR(MISR & MISR_TAPS)} XOR zero-extended {cut_resp, scan_out}; holds elsewhere.
REQ-030 Latency bist_start sampled -> bist_end=1: 2 + N_PATTERNS*(SCAN_LEN+1) + SCAN_LEN cycles (86 at defaults).
REQ-031 bist_start ignored outside IDLE; held high in DONE does not restart.
REQ-032 bist_abort=1 in SEED..COMPARE: -> IDLE next edge, pass_fail=0, bist_end never asserted; abort wins over simultaneous transition; ignored in IDLE/DONE.
REQ-033 Counters sized $clog2(max+1); no wrap within a run.

Reset
REQ-034 RST=1: state IDLE, LFSR=LFSR_SEED, MISR=0, counters=0, scan_en=0, running=0, bist_end=0, pass_fail=0, signature=0, immediately.
REQ-035 RST mid-run aborts with no completion indication; after release the engine waits for a new bist_start.

Verification
REQ-036 Idle: func_in=3'b101, no start -> cut_in=3'b101, scan_en=0, all status 0.
REQ-037 Start, defaults, model-computed GOLDEN -> bist_end=1 exactly 86 cycles after start, pass_fail=1, signature=GOLDEN.
REQ-038 Single stuck-at injected on cut_resp[0] -> bist_end=1 at cycle 86, pass_fail=0.
REQ-039 bist_abort at cycle 40 -> IDLE next cycle, running=0, bist_end stays 0, pass_fail=0.
REQ-040 RST pulse at cycle 50 -> all outputs reset values immediately; fresh start gives identical signature to REQ-037.
REQ-041 LFSR_SEED=0 -> LFSR reaches 1 after SEED+1 cycle, never stays zero; start held through DONE -> no second run.
